// File: rtl/ray_stepper_arbiter.sv
// Round-robin owner of a single ray-stepper datapath: accepts one ray job at a time,
// drives the stepper, returns its result to the owning requester, and aborts hung jobs.
module ray_stepper_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           reqValid,
  output logic [NUM_REQ-1:0]           reqReady,
  input  logic [NUM_REQ*3*WIDTH-1:0]   reqQ,
  input  logic [NUM_REQ*3*WIDTH-1:0]   reqV,
  input  logic [NUM_REQ*3*WIDTH-1:0]   reqL,
  input  logic [NUM_REQ*3*WIDTH-1:0]   reqU,
  output logic [NUM_REQ-1:0]           respValid,
  input  logic [NUM_REQ-1:0]           respReady,
  output logic [3*WIDTH-1:0]           respQ,
  output logic                         respOutOfBounds,
  output logic                         respTimeout,
  output logic                         stepStart,
  output logic [3*WIDTH-1:0]           stepQ,
  output logic [3*WIDTH-1:0]           stepV,
  output logic [3*WIDTH-1:0]           stepL,
  output logic [3*WIDTH-1:0]           stepU,
  input  logic                         stepDone,
  input  logic                         stepOutOfBounds,
  input  logic [3*WIDTH-1:0]           stepQp,
  output logic                         busy,
  output logic [IDW-1:0]               grantId
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [CW-1:0]  cnt;
  logic           timeout_hit;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // Rotating priority search: first valid requester at or above ptr, wrapping.
  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && reqValid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (win_found) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (stepDone || timeout_hit) state_nx = RESP;
      RESP:    if (respReady[grantId]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = '0;
    respValid = '0;
    stepStart = (state == START);
    busy      = (state != IDLE);
    if (state == IDLE && win_found) reqReady[win_id] = 1'b1;
    if (state == RESP) respValid[grantId] = 1'b1;
  end

  // Job operands stay on the stepper until the next accept; results are held through RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr             <= '0;
      grantId         <= '0;
      stepQ           <= '0;
      stepV           <= '0;
      stepL           <= '0;
      stepU           <= '0;
      respQ           <= '0;
      respOutOfBounds <= 1'b0;
      respTimeout     <= 1'b0;
      cnt             <= '0;
    end else begin
      unique case (state)
        IDLE: if (win_found) begin
          stepQ   <= reqQ[win_id*(3*WIDTH) +: 3*WIDTH];
          stepV   <= reqV[win_id*(3*WIDTH) +: 3*WIDTH];
          stepL   <= reqL[win_id*(3*WIDTH) +: 3*WIDTH];
          stepU   <= reqU[win_id*(3*WIDTH) +: 3*WIDTH];
          grantId <= win_id;
          ptr     <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // A real completion wins over a coincident watchdog expiry.
          if (stepDone) begin
            respQ           <= stepQp;
            respOutOfBounds <= stepOutOfBounds;
            respTimeout     <= 1'b0;
          end else if (timeout_hit) begin
            respQ           <= stepQp;
            respOutOfBounds <= 1'b1;
            respTimeout     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_stepper_arbiter.sv
// Directed bench for ray_stepper_arbiter: the bench plays both the requesters and the
// stepper, driving and sampling on the falling clock edge.
module tb_ray_stepper_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     reqValid = '0;
  logic [N-1:0]     reqReady;
  logic [N*3*W-1:0] reqQ = '0, reqV = '0, reqL = '0, reqU = '0;
  logic [N-1:0]     respValid;
  logic [N-1:0]     respReady = '0;
  logic [3*W-1:0]   respQ;
  logic             respOutOfBounds, respTimeout, stepStart, busy;
  logic [3*W-1:0]   stepQ, stepV, stepL, stepU;
  logic             stepDone = 1'b0;
  logic             stepOutOfBounds = 1'b0;
  logic [3*W-1:0]   stepQp = '0;
  logic [1:0]       grantId;

  logic [3*W-1:0] tq [N];
  logic [3*W-1:0] tv [N];
  logic [3*W-1:0] tl [N];
  logic [3*W-1:0] tu [N];

  int checks = 0;
  int errors = 0;

  ray_stepper_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqQ(reqQ), .reqV(reqV), .reqL(reqL), .reqU(reqU),
    .respValid(respValid), .respReady(respReady),
    .respQ(respQ), .respOutOfBounds(respOutOfBounds), .respTimeout(respTimeout),
    .stepStart(stepStart), .stepQ(stepQ), .stepV(stepV), .stepL(stepL), .stepU(stepU),
    .stepDone(stepDone), .stepOutOfBounds(stepOutOfBounds), .stepQp(stepQp),
    .busy(busy), .grantId(grantId)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*W-1:0] xyz(input int x, input int y, input int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction

  task automatic load_ops();
    for (int r = 0; r < N; r++) begin
      reqQ[r*3*W +: 3*W] = tq[r];
      reqV[r*3*W +: 3*W] = tv[r];
      reqL[r*3*W +: 3*W] = tl[r];
      reqU[r*3*W +: 3*W] = tu[r];
    end
  endtask

  // Entered at a falling edge in IDLE with reqValid already driven; returns at the falling
  // edge after the response handshake.
  task automatic serve(input int r, input int wait_n, input bit hang, input logic oob,
                       input logic [3*W-1:0] qp, input int bp);
    logic [N-1:0] oh;
    oh = N'(1) << r;
    #1 check("req_ready", 64'(reqReady), 64'(oh));
    @(negedge clock);
    check("start_pulse", 64'(stepStart), 64'd1);
    check("grant_id", 64'(grantId), 64'(r));
    check("step_q", 64'(stepQ), 64'(tq[r]));
    check("step_v", 64'(stepV), 64'(tv[r]));
    check("ready_busy", 64'(reqReady), 64'd0);
    @(negedge clock);
    check("start_one_cycle", 64'(stepStart), 64'd0);
    stepQp = qp;
    stepOutOfBounds = 1'b0;
    if (hang) begin
      repeat (TO - 1) @(negedge clock);
      check("no_resp_before_timeout", 64'(respValid), 64'd0);
      @(negedge clock);
    end else begin
      repeat (wait_n) @(negedge clock);
      check("no_resp_in_wait", 64'(respValid), 64'd0);
      stepDone = 1'b1;
      stepOutOfBounds = oob;
      @(negedge clock);
      stepDone = 1'b0;
      stepOutOfBounds = 1'b0;
    end
    stepQp = '0;
    check("resp_valid", 64'(respValid), 64'(oh));
    check("resp_q", 64'(respQ), 64'(qp));
    check("resp_oob", 64'(respOutOfBounds), hang ? 64'd1 : 64'(oob));
    check("resp_timeout", 64'(respTimeout), hang ? 64'd1 : 64'd0);
    check("step_u_held", 64'(stepU), 64'(tu[r]));
    respReady = ~oh;
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      check("bp_valid", 64'(respValid), 64'(oh));
      check("bp_q", 64'(respQ), 64'(qp));
      check("bp_ready", 64'(reqReady), 64'd0);
    end
    respReady = oh;
    @(negedge clock);
    respReady = '0;
    check("resp_done", 64'(respValid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin
      tq[r] = xyz(16*r + 1, 16*r + 2, 16*r + 3);
      tv[r] = xyz(256 + r, 0, 0);
      tl[r] = xyz(0, r, 0);
      tu[r] = xyz(4000 + r, 4000, 4000);
    end
    tq[2] = xyz(100, 100, 100);
    tv[2] = xyz(16'h7000, 0, 0);
    tl[2] = xyz(0, 0, 0);
    tu[2] = xyz(200, 200, 200);
    load_ops();

    #3;
    check("rst_ready", 64'(reqReady), 64'd0);
    check("rst_resp_valid", 64'(respValid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(stepStart), 64'd0);
    check("rst_step_q", 64'(stepQ), 64'd0);
    check("rst_grant", 64'(grantId), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single job from requester 2; pointer moves to 3.
    reqValid = 4'b0100;
    serve(2, 3, 1'b0, 1'b0, xyz(201, 100, 100), 0);

    // All requesters valid: rotation continues 3,0,1,2,3.
    reqValid = 4'b1111;
    serve(3, 2, 1'b0, 1'b0, xyz(3003, 1, 2), 0);
    serve(0, 1, 1'b0, 1'b0, xyz(3000, 3, 4), 10);
    serve(1, 4, 1'b0, 1'b1, xyz(3001, 5, 6), 0);
    serve(2, 2, 1'b0, 1'b0, xyz(3002, 7, 8), 0);
    serve(3, 1, 1'b0, 1'b0, xyz(3013, 9, 10), 0);

    // Watchdog on requester 1, then a normal job from it.
    reqValid = 4'b0010;
    serve(1, 0, 1'b1, 1'b0, xyz(77, 88, 99), 0);
    serve(1, 2, 1'b0, 1'b0, xyz(11, 22, 33), 0);

    // Pointer now 2: of requesters 1 and 3, requester 3 wins; reset it mid-WAIT.
    reqValid = 4'b1010;
    #1 check("rr_skip", 64'(reqReady), 64'b1000);
    @(negedge clock);
    reqValid = '0;
    @(negedge clock);
    check("wait_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_step_q", 64'(stepQ), 64'd0);
    check("arst_grant", 64'(grantId), 64'd0);
    check("arst_resp_valid", 64'(respValid), 64'd0);
    stepDone = 1'b1;
    @(negedge clock);
    stepDone = 1'b0;
    check("arst_held_resp", 64'(respValid), 64'd0);
    reset = 1'b1;
    reqValid = 4'b1111;
    serve(0, 2, 1'b0, 1'b0, xyz(5, 6, 7), 0);
    reqValid = '0;
    @(negedge clock);
    check("final_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ray_stepper_arbiter.md
# ray_stepper_arbiter

Round-robin controller that shares a single ray-stepper datapath between NUM_REQ requesters (per-pixel ray-march engines). It accepts one ray job at a time from a valid/ready request port and holds the job's q, v, l and u on the stepper inputs for the whole operation. It issues the one-cycle start pulse, waits for stepper done, and returns qp/outOfBounds to the originating requester on a one-hot valid/ready response port. A watchdog aborts jobs whose done never arrives.

## Interface
- WIDTH, 16, coordinate width per axis; matches the stepper.
- NUM_REQ, 4, number of requesters (≥2); IDW = $clog2(NUM_REQ) is derived.
- TIMEOUT, 64, maximum WAIT cycles before abort (≥ WIDTH+4).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears immediately while low.
- reqValid  in  NUM_REQ  job offered by requester r.
- reqReady  out  NUM_REQ  one-hot grant; accept = reqValid[r] & reqReady[r].
- reqQ, reqV, reqL, reqU  in  NUM_REQ*3*WIDTH each  requester r, axis i at [(3r+i)*WIDTH +: WIDTH].
- respValid  out  NUM_REQ  one-hot result valid to the job owner.
- respReady  in  NUM_REQ  owner accepts result.
- respQ  out  3*WIDTH  exit position; axis i at [i*WIDTH +: WIDTH].
- respOutOfBounds  out  1  stepper flagged outOfBounds, or timeout occurred.
- respTimeout  out  1  job aborted by watchdog.
- stepStart  out  1  start pulse to the stepper.
- stepQ, stepV, stepL, stepU  out  3*WIDTH each  registered job operands.
- stepDone  in  1  stepper done.
- stepOutOfBounds  in  1  stepper outOfBounds.
- stepQp  in  3*WIDTH  stepper qp.
- busy  out  1  high in any state other than IDLE.
- grantId  out  IDW  owner of the current or last job.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - Winner is the first r with reqValid[r], searching upward from pointer ptr and wrapping.
  - reqReady[winner] = 1 combinationally; all other reqReady bits are 0. No reqValid means all reqReady are 0.
  - On accept: latch that requester's q/v/l/u into step* registers, set grantId = winner, set ptr = (winner+1) mod NUM_REQ, go to START.
- START:
  - stepStart = 1 for exactly this cycle. Go to WAIT; clear the watchdog counter.
- WAIT:
  - stepStart = 0 and step* are held. The counter increments each cycle.
  - If stepDone = 1: capture stepQp→respQ and stepOutOfBounds→respOutOfBounds, set respTimeout = 0, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: capture stepQp, set respOutOfBounds = 1 and respTimeout = 1, go to RESP.
  - stepDone takes priority when both conditions hold in the same cycle.
- RESP:
  - respValid[grantId] = 1; other bits are 0. respQ, respOutOfBounds and respTimeout are stable.
  - When respReady[grantId] = 1, go to IDLE. respReady bits of other requesters are ignored.
- stepL/stepU are constant from the START cycle until the next accept, which satisfies the stepper hold rule.
- A timed-out stepper is not reset. The next START pulse reloads it, because start overrides a running stepper.
- Reset (async assert, any state): state = IDLE, ptr = 0, grantId = 0, stepStart = 0, step* = 0, respQ = 0, respOutOfBounds = 0, respTimeout = 0, counter = 0. Combinationally reqReady = 0, respValid = 0, busy = 0. An in-flight job is dropped without a response.
- Release is synchronised by the system. The first accept is possible in the first IDLE cycle after release.

## Timing
- Accept at cycle t (IDLE) → stepStart at t+1 → WAIT from t+2.
- stepDone first seen high at cycle d ≥ t+3 → respValid from d+1.
- Response handshake at cycle h → IDLE at h+1; the next accept is possible at h+1.
- Minimum job period: 4 cycles plus stepper run time.
- Stepper done is high at WAIT entry only if the stepper is broken; the block treats that as a valid completion.
- Timeout: with no done, respValid rises at t+2+TIMEOUT.
- One job in flight at a time; no request queueing inside the block.

## Test plan
- Single job: NUM_REQ=4, r2 offers q=(100,100,100), v=(0x7000,0,0), l=(0,0,0), u=(200,200,200) → reqReady=0100 for one cycle, one stepStart pulse, respValid=0100 with respQ[0]≈201, respOutOfBounds=0, respTimeout=0.
- Round-robin fairness: all four requesters valid continuously → grant order 0,1,2,3,0,…; each requester receives only its own result.
- Response backpressure: hold respReady low for 10 cycles → respValid and respQ stay stable, reqReady stays 0000, then accept proceeds.
- Watchdog: stepper model keeps done low → after TIMEOUT WAIT cycles, respTimeout=1, respOutOfBounds=1, and the next job runs normally.
- Async reset mid-WAIT: assert reset between clock edges → outputs clear immediately, ptr=0, no response for the dropped job, and requester 0 wins first after release.
- Out-of-bounds passthrough: stepper returns outOfBounds=1 → respOutOfBounds=1, respTimeout=0.
